// File: rtl/coil_dwell_guard.sv
// Per-channel coil output guard: registers the comparator request onto the pin and enforces
// max dwell, min off time and enable gating, with dwell/fault/miss status for readback.
module coil_dwell_guard #(
    parameter int unsigned TCNT_W = 24,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_ena,
    input  logic              i_hwag_start,
    input  logic              i_coil_req,
    input  logic [TCNT_W-1:0] i_max_dwell,
    input  logic [TCNT_W-1:0] i_min_off,
    input  logic              i_fault_clr,
    output logic              o_coil_out,
    output logic [TCNT_W-1:0] o_dwell_last,
    output logic              o_dwell_timeout,
    output logic [FCNT_W-1:0] o_fault_cnt,
    output logic [FCNT_W-1:0] o_miss_cnt
);

    // Any two-bit hop through StCharge only passes intermediate codes that decode as coil off.
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCharge  = 2'b01,
        StHoldoff = 2'b10,
        StLockout = 2'b11
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [TCNT_W-1:0]   r_timer;
    logic [TCNT_W-1:0]   w_timer_d;
    logic [TCNT_W-1:0]   r_dwell_last;
    logic [TCNT_W-1:0]   w_dwell_last_d;
    logic                r_req_d;
    logic                r_timeout;
    logic                w_timeout_d;
    logic [FCNT_W-1:0]   r_fault_cnt;
    logic [FCNT_W-1:0]   w_fault_cnt_d;
    logic [FCNT_W-1:0]   r_miss_cnt;
    logic [FCNT_W-1:0]   w_miss_cnt_d;
    logic                w_req_rise;
    logic                w_fault_evt;
    logic                w_miss_evt;
    logic [TCNT_W-1:0]   w_min_off_eff;

    assign w_req_rise    = i_coil_req & ~r_req_d;
    assign w_min_off_eff = (i_min_off == '0) ? TCNT_W'(1) : i_min_off;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_req_d      <= 1'b0;
            r_dwell_last <= '0;
            r_timeout    <= 1'b0;
            r_fault_cnt  <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_timer      <= w_timer_d;
            r_req_d      <= i_coil_req;
            r_dwell_last <= w_dwell_last_d;
            r_timeout    <= w_timeout_d;
            r_fault_cnt  <= w_fault_cnt_d;
            r_miss_cnt   <= w_miss_cnt_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_timer_d      = r_timer;
        w_dwell_last_d = r_dwell_last;
        w_fault_evt    = 1'b0;
        w_miss_evt     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req_rise) begin
                    if (i_ena && i_hwag_start) begin
                        w_state_d = StCharge;
                        w_timer_d = TCNT_W'(1);
                    end else if (i_ena) begin
                        w_miss_evt = 1'b1;
                    end
                end
            end
            StCharge: begin
                if (!i_ena || !i_hwag_start) begin
                    w_state_d = StHoldoff;
                    w_timer_d = TCNT_W'(1);
                end else if (!i_coil_req) begin
                    w_state_d      = StHoldoff;
                    w_dwell_last_d = r_timer;
                    w_timer_d      = TCNT_W'(1);
                end else if ((i_max_dwell != '0) && (r_timer == i_max_dwell)) begin
                    w_state_d      = StLockout;
                    w_dwell_last_d = r_timer;
                    w_fault_evt    = 1'b1;
                end else if (r_timer != '1) begin
                    w_timer_d = r_timer + TCNT_W'(1);
                end
            end
            StHoldoff: begin
                w_miss_evt = w_req_rise;
                if (r_timer >= w_min_off_eff) begin
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer + TCNT_W'(1);
                end
            end
            StLockout: begin
                w_miss_evt = w_req_rise;
                // Wait out the stale request so its tail cannot re-fire the coil.
                if (!i_coil_req) begin
                    w_state_d = StHoldoff;
                    w_timer_d = TCNT_W'(1);
                end
            end
        endcase

        // A clear coinciding with an event leaves exactly that event recorded.
        if (i_fault_clr) begin
            w_timeout_d   = w_fault_evt;
            w_fault_cnt_d = w_fault_evt ? FCNT_W'(1) : '0;
            w_miss_cnt_d  = w_miss_evt ? FCNT_W'(1) : '0;
        end else begin
            w_timeout_d   = r_timeout | w_fault_evt;
            w_fault_cnt_d = (w_fault_evt && (r_fault_cnt != '1)) ? r_fault_cnt + FCNT_W'(1)
                                                                  : r_fault_cnt;
            w_miss_cnt_d  = (w_miss_evt && (r_miss_cnt != '1)) ? r_miss_cnt + FCNT_W'(1)
                                                                : r_miss_cnt;
        end
    end

    always_comb begin
        o_coil_out      = (r_state == StCharge);
        o_dwell_last    = r_dwell_last;
        o_dwell_timeout = r_timeout;
        o_fault_cnt     = r_fault_cnt;
        o_miss_cnt      = r_miss_cnt;
    end

endmodule

// File: tb/tb_coil_dwell_guard.sv
// Scoreboard bench for coil_dwell_guard: stimulus queues expected pulses and status snapshots,
// a negedge monitor pops them when the coil pulse ends or a snapshot is requested.
module tb_coil_dwell_guard;

    typedef struct {
        string name;
        int    start;
        int    len;
        int    coil;
        int    dwell;
        int    to;
        int    fault;
        int    miss;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ena;
    logic        hwag_start;
    logic        coil_req;
    logic [23:0] max_dwell;
    logic [23:0] min_off;
    logic        fault_clr;
    logic        coil_out;
    logic [23:0] dwell_last;
    logic        dwell_timeout;
    logic [7:0]  fault_cnt;
    logic [7:0]  miss_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic snap = 1'b0;
    exp_t pulse_q[$];
    exp_t snap_q[$];

    coil_dwell_guard dut (
        .i_clk          (clk),
        .i_nrst         (nrst),
        .i_ena          (ena),
        .i_hwag_start   (hwag_start),
        .i_coil_req     (coil_req),
        .i_max_dwell    (max_dwell),
        .i_min_off      (min_off),
        .i_fault_clr    (fault_clr),
        .o_coil_out     (coil_out),
        .o_dwell_last   (dwell_last),
        .o_dwell_timeout(dwell_timeout),
        .o_fault_cnt    (fault_cnt),
        .o_miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input string name, input int len, input int d, input int to,
                              input int f, input int m);
        exp_t e;
        e = '{name: name, start: cyc + 1, len: len, coil: 0, dwell: d, to: to, fault: f,
              miss: m};
        pulse_q.push_back(e);
    endtask

    task automatic pulse(input string name, input int hold, input int len, input int d,
                         input int to, input int f, input int m);
        push_pulse(name, len, d, to, f, m);
        coil_req = 1'b1;
        step(hold);
        coil_req = 1'b0;
    endtask

    task automatic do_snap(input string name, input int c, input int d, input int to,
                           input int f, input int m);
        exp_t e;
        e = '{name: name, start: 0, len: 0, coil: c, dwell: d, to: to, fault: f, miss: m};
        snap_q.push_back(e);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
    endtask

    task automatic set_limits(input int mx, input int mn);
        max_dwell = 24'(mx);
        min_off   = 24'(mn);
    endtask

    // Monitor: compares whenever the coil pulse ends or a snapshot is requested.
    initial begin
        exp_t cur;
        exp_t s;
        logic prev = 1'b0;
        logic in_pulse = 1'b0;
        int   hi = 0;
        forever begin
            @(negedge clk);
            if (snap) begin
                if (snap_q.size() == 0) begin
                    chk("snap_underflow", 1, 0);
                end else begin
                    s = snap_q.pop_front();
                    chk({s.name, "/coil"}, int'(coil_out), s.coil);
                    chk({s.name, "/dwell_last"}, int'(dwell_last), s.dwell);
                    chk({s.name, "/timeout"}, int'(dwell_timeout), s.to);
                    chk({s.name, "/fault_cnt"}, int'(fault_cnt), s.fault);
                    chk({s.name, "/miss_cnt"}, int'(miss_cnt), s.miss);
                end
            end
            if (coil_out === 1'b1 && prev !== 1'b1) begin
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse_at_cycle", cyc, -1);
                    in_pulse = 1'b0;
                end else begin
                    cur = pulse_q.pop_front();
                    in_pulse = 1'b1;
                    hi = 0;
                    chk({cur.name, "/start_cycle"}, cyc, cur.start);
                end
            end
            if (coil_out === 1'b1) hi++;
            if (coil_out === 1'b0 && prev === 1'b1 && in_pulse) begin
                in_pulse = 1'b0;
                chk({cur.name, "/high_cycles"}, hi, cur.len);
                chk({cur.name, "/dwell_last"}, int'(dwell_last), cur.dwell);
                chk({cur.name, "/timeout"}, int'(dwell_timeout), cur.to);
                chk({cur.name, "/fault_cnt"}, int'(fault_cnt), cur.fault);
                chk({cur.name, "/miss_cnt"}, int'(miss_cnt), cur.miss);
            end
            prev = coil_out;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got cycle %0d, expected completion before it", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; ena = 1'b1; hwag_start = 1'b1; coil_req = 1'b0; fault_clr = 1'b0;
        set_limits(100, 10);
        step(3);
        do_snap("reset", 0, 0, 0, 0, 0);
        nrst = 1'b1;
        step(2);

        pulse("normal", 40, 40, 40, 0, 0, 0);
        // Fall edge is one cycle after return; rises at +3 and +10 into holdoff are missed.
        step(3); coil_req = 1'b1;
        step(2); coil_req = 1'b0;
        step(5); coil_req = 1'b1;
        step(2); coil_req = 1'b0;
        step(1);
        do_snap("holdoff_miss", 0, 40, 0, 0, 2);
        pulse("after_holdoff", 20, 20, 20, 0, 0, 2);
        step(12);

        set_limits(50, 10);
        push_pulse("max_dwell", 50, 50, 1, 1, 2);
        coil_req = 1'b1;
        step(100);
        do_snap("lockout", 0, 50, 1, 1, 2);
        step(99);
        coil_req = 1'b0;
        step(12);

        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        do_snap("clear", 0, 50, 0, 0, 0);
        pulse("boundary", 50, 50, 50, 0, 0, 0);
        step(12);

        set_limits(0, 10);
        pulse("limit_off", 150, 150, 150, 0, 0, 0);
        step(12);

        set_limits(100, 10);
        push_pulse("gated", 5, 150, 0, 0, 0);
        coil_req = 1'b1;
        step(5); hwag_start = 1'b0;
        step(5); coil_req = 1'b0;
        step(12);
        coil_req = 1'b1; step(2); coil_req = 1'b0; step(2);
        do_snap("gated_miss", 0, 150, 0, 0, 1);

        hwag_start = 1'b1; ena = 1'b0;
        coil_req = 1'b1; step(3);
        do_snap("disabled_rise", 0, 150, 0, 0, 1);
        ena = 1'b1; step(5);
        do_snap("level_no_fire", 0, 150, 0, 0, 1);
        coil_req = 1'b0; step(2);

        hwag_start = 1'b0;
        for (int i = 0; i < 260; i++) begin
            coil_req = 1'b1; step(1); coil_req = 1'b0; step(1);
        end
        do_snap("miss_saturate", 0, 150, 0, 0, 255);
        hwag_start = 1'b1;
        step(2);

        set_limits(20, 10);
        push_pulse("timeout_with_clear", 20, 20, 1, 1, 0);
        coil_req = 1'b1;
        step(20); fault_clr = 1'b1;
        step(1);  fault_clr = 1'b0;
        step(19); coil_req = 1'b0;
        step(12);

        set_limits(100, 10);
        push_pulse("reset_mid_charge", 10, 0, 0, 0, 0);
        coil_req = 1'b1;
        step(10); nrst = 1'b0;
        step(1);
        do_snap("after_reset", 0, 0, 0, 0, 0);
        coil_req = 1'b0;
        step(2);
        nrst = 1'b1;
        step(5);

        chk("pending_pulses", pulse_q.size(), 0);
        chk("pending_snaps", snap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coil_dwell_guard.md
Name: coil_dwell_guard

Overview:
- Output-protection stage between the coil set/reset comparator request (set & ~reset) and the coil pin.
- One instance per coil channel.
- Passes the request through with one clock of registration. Enforces a maximum dwell (forced cut-off), a minimum off time between sparks, and start/enable gating.
- Reports the last measured dwell, a sticky timeout flag and saturating fault/miss counters for SPI readback.

Parameters:
TCNT_W, 24, width of dwell/off timers and limit inputs
FCNT_W, 8, width of fault and miss counters

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
ena  in  1  channel enable
hwag_start  in  1  angle generator synchronised; low = engine not tracked
coil_req  in  1  raw coil request from comparators
max_dwell  in  TCNT_W  max charge time in clk cycles; 0 = limit disabled
min_off  in  TCNT_W  min coil-off time in clk cycles; 0 treated as 1
fault_clr  in  1  single-cycle clear of timeout flag and counters
coil_out  out  1  coil gate drive
dwell_last  out  TCNT_W  high-cycle count of last completed charge
dwell_timeout  out  1  sticky: a charge was force-terminated
fault_cnt  out  FCNT_W  forced terminations, saturating
miss_cnt  out  FCNT_W  request rising edges ignored, saturating

Behaviour:
- Reset applies on the rising clk edge while nrst=0:
  - state=IDLE, timer=0, req_d=0.
  - coil_out=0, dwell_last=0, dwell_timeout=0, fault_cnt=0, miss_cnt=0.
- Edge detection: req_d <= coil_req every cycle; req_rise = coil_req & ~req_d.
- coil_out = (state==CHARGE), decoded from the state register, glitch-free. Latency is 1 clk from the sampled edge to the pin, both rising and falling.
- IDLE:
  - Go to CHARGE with timer<=1 when req_rise & ena & hwag_start.
  - A level-high request without an edge never fires.
- CHARGE exit rules, evaluated per edge in this priority:
  1. ~ena | ~hwag_start: go to HOLDOFF, timer<=1. Abort, no fault, dwell_last unchanged.
  2. ~coil_req: go to HOLDOFF, dwell_last<=timer, timer<=1. Normal end; coil was high exactly timer cycles.
  3. max_dwell!=0 & timer==max_dwell: go to LOCKOUT. dwell_timeout<=1, fault_cnt++ (saturating), dwell_last<=timer. Coil was high exactly max_dwell cycles.
  4. Otherwise timer<=timer+1, saturating at all-ones.
- Request low on the same edge that max_dwell is reached counts as a normal end: no fault.
- LOCKOUT:
  - coil_out=0.
  - Stay until coil_req sampled 0, then go to HOLDOFF with timer<=1. This prevents re-firing on the tail of the stale request.
- HOLDOFF:
  - coil_out=0.
  - If timer >= max(min_off,1), go to IDLE; else timer++.
  - HOLDOFF occupies max(min_off,1) cycles.
- Miss counting: a req_rise in HOLDOFF or LOCKOUT, or in IDLE with ena & ~hwag_start, increments miss_cnt (saturating). It does not start a charge.
- Limit inputs are sampled live each cycle. Lowering max_dwell below the current timer value does not cut the charge: the equality check, not >=, is the rule, and software must change limits only while hwag_start=0.
- fault_clr:
  - Clears dwell_timeout, fault_cnt and miss_cnt.
  - If a set/increment event occurs on the same edge, the event wins: flag=1, the affected counter=1, any other counter=0.
  - Does not affect state or coil_out.
- Reset mid-charge: coil_out is 0 in the cycle after the reset edge.
- Expected RTL size: 150-250 lines (FSM, timer, two counters, edge detector).

Test Plan:
- Normal charge:
  - Stimulus: nrst released, ena=1, hwag_start=1, max_dwell=100, min_off=10; coil_req high for 40 cycles.
  - Response: coil_out high exactly 40 cycles, delayed 1 clk; dwell_last=40; no fault; return to IDLE 10 cycles after coil_out falls.
- Max dwell cut-off:
  - Stimulus: max_dwell=50, coil_req high 200 cycles.
  - Response: coil_out high exactly 50 cycles; dwell_timeout=1; fault_cnt=1; dwell_last=50; coil stays low until req falls, then 10-cycle holdoff.
- Boundary:
  - Stimulus: req held exactly 50 cycles with max_dwell=50.
  - Response: normal end; dwell_timeout stays 0.
- Holdoff and miss:
  - Stimulus: second req rising 3 cycles after the first falls (min_off=10).
  - Response: no charge, miss_cnt=1. A req rising 12 cycles after the fall charges normally.
- Gating:
  - Stimulus: hwag_start dropped 5 cycles into a charge.
  - Response: coil_out low next clk; fault_cnt unchanged; dwell_last unchanged. A req_rise with hwag_start=0 gives miss_cnt+1.
- Reset and clear:
  - Stimulus: nrst=0 mid-charge.
  - Response: all outputs 0 after that edge.
  - Stimulus: fault_clr coincident with a timeout.
  - Response: dwell_timeout=1, fault_cnt=1, miss_cnt=0.
